// File: rtl/mips_pkg.sv
// Shared opcode constants, controller state encoding and access-size helper
// for the MEM-stage memory access unit.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_UNALIGNED
    } size_e;

    // LWL/LWR are the only word accesses allowed at any byte offset.
    function automatic size_e access_size(input logic [5:0] op, input logic is_store);
        size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (op)
                OP_SB:   sz = SZ_BYTE;
                OP_SH:   sz = SZ_HALF;
                OP_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (op)
                OP_LB, OP_LBU:   sz = SZ_BYTE;
                OP_LH, OP_LHU:   sz = SZ_HALF;
                OP_LWL, OP_LWR:  sz = SZ_UNALIGNED;
                OP_LW:           sz = SZ_WORD;
                default:         sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a little-endian read word and
// extends it, or merges the word into rt for LWL/LWR.
module load_extend
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] rt,
    output logic [31:0] result
);

    logic [5:0]  sh_right;
    logic [5:0]  sh_left;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        sh_right = {1'b0, offset, 3'b000};
        sh_left  = 6'd24 - sh_right;
        byte_sel = 8'(word >> sh_right);
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h000000, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0000, half_sel};
            // rt keeps the low bytes the shifted word does not cover
            OP_LWL:  result = (word << sh_left) | (rt & ~(32'hFFFF_FFFF << sh_left));
            OP_LWR:  result = (word >> sh_right) | (rt & ~(32'hFFFF_FFFF >> sh_right));
            default: result = word;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// MEM-stage controller: issues one load/store on a waitrequest bus while
// stalling the pipeline, then returns the extended load result.
//
// state     | meaning
// ST_IDLE   | waiting for an aligned load/store request
// ST_ACCESS | strobe on the bus until waitrequest drops
// ST_DONE   | result valid, stall released for one cycle
module memory_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_to_register_memory,
    input  logic              memory_write_memory,
    input  logic [5:0]        op_memory,
    input  logic [31:0]       ALU_output_memory,
    input  logic [31:0]       write_data_memory,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_read,
    output logic              data_write,
    output logic [3:0]        data_byteenable,
    output logic [31:0]       data_writedata,
    input  logic              data_waitrequest,
    input  logic [31:0]       data_readdata,
    output logic [31:0]       read_data_memory,
    output logic              stall_memory,
    output logic              address_error_memory
);

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        offset_q, offset_d;
    logic [31:0]       rt_q, rt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_store;
    logic              req_any;
    size_e             req_size;
    logic              misaligned;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic [31:0]       ext_result;
    logic              stall;
    logic              addr_err;

    load_extend u_load_extend (
        .op     (op_q),
        .offset (offset_q),
        .word   (data_readdata),
        .rt     (rt_q),
        .result (ext_result)
    );

    always_comb begin
        req_store  = memory_write_memory;
        req_any    = memory_to_register_memory | memory_write_memory;
        req_size   = access_size(op_memory, req_store);
        misaligned = ((req_size == SZ_HALF) && ALU_output_memory[0]) ||
                     ((req_size == SZ_WORD) && (ALU_output_memory[1:0] != 2'b00));
        req_be     = 4'b1111;
        req_wdata  = write_data_memory;
        if (req_store) begin
            case (req_size)
                SZ_BYTE: begin
                    req_be    = 4'b0001 << ALU_output_memory[1:0];
                    req_wdata = {4{write_data_memory[7:0]}};
                end
                SZ_HALF: begin
                    req_be    = ALU_output_memory[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{write_data_memory[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = write_data_memory;
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        op_d       = op_q;
        offset_d   = offset_q;
        rt_d       = rt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        stall      = 1'b0;
        addr_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (misaligned) begin
                        addr_err = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_d    = ST_ACCESS;
                        is_store_d = req_store;
                        op_d       = op_memory;
                        offset_d   = ALU_output_memory[1:0];
                        rt_d       = write_data_memory;
                        addr_d     = {ALU_output_memory[ADDR_W-1:2], 2'b00};
                        be_d       = req_be;
                        wdata_d    = req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                if (!data_waitrequest) begin
                    state_d = ST_DONE;
                    if (!is_store_q) begin
                        rdata_d = ext_result;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            op_q       <= 6'h00;
            offset_q   <= 2'b00;
            rt_q       <= 32'h0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            op_q       <= op_d;
            offset_q   <= offset_d;
            rt_q       <= rt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Combinational pulses are masked while reset is held so the pipeline
    // sees a quiet unit from the reset edge onward.
    assign stall_memory         = stall & ~reset;
    assign address_error_memory = addr_err & ~reset;
    assign data_read            = (state_q == ST_ACCESS) && !is_store_q;
    assign data_write           = (state_q == ST_ACCESS) && is_store_q;
    assign data_address         = addr_q;
    assign data_byteenable      = be_q;
    assign data_writedata       = wdata_q;
    assign read_data_memory     = rdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: drives loads/stores through the
// waitrequest handshake and checks strobes, stall, lanes and results.
module tb_memory_access_unit;

    logic        clk;
    logic        reset;
    logic        memory_to_register_memory;
    logic        memory_write_memory;
    logic [5:0]  op_memory;
    logic [31:0] ALU_output_memory;
    logic [31:0] write_data_memory;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic        data_waitrequest;
    logic [31:0] data_readdata;
    logic [31:0] read_data_memory;
    logic        stall_memory;
    logic        address_error_memory;

    int n_checks;
    int n_errors;

    int n_read, n_write, n_stall, n_err, n_both, timeout;
    logic [31:0] cap_be, cap_wd, cap_addr, result;
    int post_stall, post_err, post_strobe;
    logic [31:0] post_result;

    memory_access_unit #(.ADDR_W(32)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .memory_to_register_memory (memory_to_register_memory),
        .memory_write_memory       (memory_write_memory),
        .op_memory                 (op_memory),
        .ALU_output_memory         (ALU_output_memory),
        .write_data_memory         (write_data_memory),
        .data_address              (data_address),
        .data_read                 (data_read),
        .data_write                (data_write),
        .data_byteenable           (data_byteenable),
        .data_writedata            (data_writedata),
        .data_waitrequest          (data_waitrequest),
        .data_readdata             (data_readdata),
        .read_data_memory          (read_data_memory),
        .stall_memory              (stall_memory),
        .address_error_memory      (address_error_memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts just after a negedge; ends one cycle after the access finishes.
    task automatic do_access(input logic ld, input logic st, input logic [5:0] op,
                             input logic [31:0] addr, input logic [31:0] rt,
                             input logic [31:0] rd, input int nwait);
        int acc;
        int cyc;
        n_read = 0; n_write = 0; n_stall = 0; n_err = 0; n_both = 0; timeout = 0;
        cap_be = 32'h0; cap_wd = 32'h0; cap_addr = 32'h0;
        memory_to_register_memory = ld;
        memory_write_memory       = st;
        op_memory                 = op;
        ALU_output_memory         = addr;
        write_data_memory         = rt;
        data_readdata             = rd;
        data_waitrequest          = 1'b1;
        acc = 0;
        cyc = 0;
        #1;
        while (1) begin
            if (stall_memory) n_stall++;
            if (address_error_memory) n_err++;
            if (data_read) n_read++;
            if (data_write) n_write++;
            if (data_read && data_write) n_both++;
            if (data_read || data_write) begin
                acc++;
                cap_be   = {28'h0, data_byteenable};
                cap_wd   = data_writedata;
                cap_addr = data_address;
                data_waitrequest = (acc <= nwait);
            end
            if (!stall_memory) break;
            cyc++;
            if (cyc > 20) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        result = read_data_memory;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
        data_waitrequest          = 1'b0;
        @(negedge clk);
        #1;
        post_stall  = stall_memory ? 1 : 0;
        post_err    = address_error_memory ? 1 : 0;
        post_strobe = (data_read || data_write) ? 1 : 0;
        post_result = read_data_memory;
    endtask

    initial begin
        int strobes;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
        op_memory                 = 6'h00;
        ALU_output_memory         = 32'h0;
        write_data_memory         = 32'h0;
        data_waitrequest          = 1'b0;
        data_readdata             = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_rdata", read_data_memory, 32'h0);
        check("rst_be",    32'(data_byteenable), 32'h0);
        check("rst_wdata", data_writedata, 32'h0);
        check("rst_addr",  data_address, 32'h0);
        check("rst_strobe", 32'(data_read | data_write), 32'h0);
        check("rst_stall", 32'(stall_memory | address_error_memory), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        #1;

        // LW with two waitrequest cycles
        do_access(1'b1, 1'b0, 6'h23, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
        check("lw_timeout", timeout, 0);
        check("lw_nread",   n_read, 3);
        check("lw_nstall",  n_stall, 4);
        check("lw_nwrite",  n_write, 0);
        check("lw_result",  result, 32'hDEAD_BEEF);
        check("lw_be",      cap_be, 32'hF);
        check("lw_addr",    cap_addr, 32'h0000_0100);
        check("lw_post_stall", post_stall, 0);
        check("lw_hold",    post_result, 32'hDEAD_BEEF);

        // LB / LBU from lane 3
        do_access(1'b1, 1'b0, 6'h20, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
        check("lb_result", result, 32'hFFFF_FF80);
        check("lb_be",     cap_be, 32'hF);
        check("lb_addr",   cap_addr, 32'h0000_0100);
        check("lb_nstall", n_stall, 2);
        check("lb_nread",  n_read, 1);
        do_access(1'b1, 1'b0, 6'h24, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
        check("lbu_result", result, 32'h0000_0080);

        // LH upper half (sign), LHU lower half
        do_access(1'b1, 1'b0, 6'h21, 32'h0000_0102, 32'h0, 32'h8011_2233, 0);
        check("lh_result", result, 32'hFFFF_8011);
        do_access(1'b1, 1'b0, 6'h25, 32'h0000_0100, 32'h0, 32'h8011_2233, 0);
        check("lhu_result", result, 32'h0000_2233);

        // SH upper half
        do_access(1'b0, 1'b1, 6'h29, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
        check("sh_be",     cap_be, 32'hC);
        check("sh_wdata",  cap_wd, 32'hABCD_ABCD);
        check("sh_addr",   cap_addr, 32'h0000_0200);
        check("sh_nwrite", n_write, 1);
        check("sh_nread",  n_read, 0);
        check("sh_hold",   post_result, 32'h0000_2233);

        // SB lane 1
        do_access(1'b0, 1'b1, 6'h28, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0);
        check("sb_be",    cap_be, 32'h2);
        check("sb_wdata", cap_wd, 32'hA5A5_A5A5);

        // LWL / LWR merge at offset 1
        do_access(1'b1, 1'b0, 6'h22, 32'h0000_0301, 32'h1122_3344, 32'hAABB_CCDD, 0);
        check("lwl_result", result, 32'hCCDD_3344);
        do_access(1'b1, 1'b0, 6'h26, 32'h0000_0301, 32'h1122_3344, 32'hAABB_CCDD, 0);
        check("lwr_result", result, 32'h11AA_BBCC);

        // Misaligned SW
        do_access(1'b0, 1'b1, 6'h2B, 32'h0000_0002, 32'h5555_5555, 32'h0, 0);
        check("sw_mis_err",    n_err, 1);
        check("sw_mis_write",  n_write, 0);
        check("sw_mis_stall",  n_stall, 0);
        check("sw_mis_posterr", post_err, 0);
        check("sw_mis_poststrobe", post_strobe, 0);
        check("sw_mis_hold",   post_result, 32'h11AA_BBCC);

        // Misaligned LH
        do_access(1'b1, 1'b0, 6'h21, 32'h0000_0101, 32'h0, 32'h0, 0);
        check("lh_mis_err",  n_err, 1);
        check("lh_mis_read", n_read, 0);

        // Both flags: store wins
        do_access(1'b1, 1'b1, 6'h2B, 32'h0000_0104, 32'h1234_5678, 32'hFFFF_FFFF, 1);
        check("both_nwrite", n_write, 1 + 1);
        check("both_nread",  n_read, 0);
        check("both_wdata",  cap_wd, 32'h1234_5678);
        check("both_be",     cap_be, 32'hF);
        check("both_none",   n_both, 0);

        // Unknown opcode behaves as word access
        do_access(1'b1, 1'b0, 6'h3F, 32'h0000_0108, 32'h0, 32'hCAFE_F00D, 0);
        check("unk_result", result, 32'hCAFE_F00D);
        do_access(1'b1, 1'b0, 6'h3F, 32'h0000_010A, 32'h0, 32'h0, 0);
        check("unk_mis_err", n_err, 1);

        // Reset in the middle of a waited access
        memory_to_register_memory = 1'b1;
        op_memory                 = 6'h23;
        ALU_output_memory         = 32'h0000_0100;
        data_waitrequest          = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_inaccess", 32'(data_read), 32'h1);
        reset = 1'b1;
        memory_to_register_memory = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_strobe", 32'(data_read | data_write), 32'h0);
        check("rst_mid_stall",  32'(stall_memory), 32'h0);
        check("rst_mid_err",    32'(address_error_memory), 32'h0);
        check("rst_mid_rdata",  read_data_memory, 32'h0);
        check("rst_mid_addr",   data_address, 32'h0);
        reset = 1'b0;
        data_waitrequest = 1'b0;
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (data_read || data_write || stall_memory) strobes++;
        end
        check("rst_no_retry", strobes, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of the data bus.
REQ-002 SHALL have ports clk (in, 1, clock) and reset (in, 1, synchronous active-high reset); one clock; reset is synchronous and active-high.
REQ-003 SHALL have memory_to_register_memory (in, 1, load in MEM stage) and memory_write_memory (in, 1, store in MEM stage).
REQ-004 SHALL have op_memory (in, 6, opcode), ALU_output_memory (in, 32, effective byte address) and write_data_memory (in, 32, rt value: store data, or LWL/LWR merge source).
REQ-005 SHALL have data_address (out, ADDR_W, word-aligned address), data_read (out, 1), data_write (out, 1), data_byteenable (out, 4), data_writedata (out, 32), data_waitrequest (in, 1) and data_readdata (in, 32).
REQ-006 SHALL have read_data_memory (out, 32, extended load result), stall_memory (out, 1, freeze EX/MEM and earlier) and address_error_memory (out, 1, misaligned access pulse).

Function
REQ-007 SHALL implement states IDLE, ACCESS and DONE.
REQ-008 IDLE: a request is memory_to_register_memory or memory_write_memory high with an aligned address; a request drives stall_memory=1 combinationally and moves to ACCESS next cycle.
REQ-009 ACCESS: SHALL hold data_read (load) or data_write (store), data_address={ALU_output_memory[ADDR_W-1:2],2'b00}, byteenable and writedata stable while data_waitrequest=1; stall_memory=1.
REQ-010 ACCESS with data_waitrequest=0: SHALL complete the transfer that cycle, register the extended load result, and move to DONE.
REQ-011 DONE: stall_memory=0, read_data_memory valid, no bus strobe; SHALL return to IDLE next cycle without re-issuing the same instruction.
REQ-012 Minimum latency: 3 cycles from request seen in IDLE to the pipeline advancing; each extra waitrequest cycle adds one.
REQ-013 data_read and data_write SHALL never both be high; both SHALL be 0 outside ACCESS.
REQ-014 Byte lanes are little-endian: SB enables lane addr[1:0]; SH enables 0011 or 1100 by addr[1]; SW enables 1111; data_writedata SHALL replicate the byte or halfword across the lanes.
REQ-015 Loads: LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW passes the word; loads use byteenable 1111.
REQ-016 LWL with offset k: result = (word << 8*(3-k)) OR (rt AND low 8*(3-k) bits mask); LWR: result = (word >> 8k) OR (rt AND NOT(FFFFFFFF >> 8k)).
REQ-017 Misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0): no bus access, no stall, address_error_memory=1 for that cycle only.
REQ-018 Neither load nor store flag high: stays IDLE, stall_memory=0, read_data_memory holds its last value.
REQ-019 Unrecognised opcode with a flag set SHALL be treated as LW/SW width.
REQ-020 If both flags are high, store SHALL take priority.

Reset
REQ-021 On reset at any clock edge, including mid-ACCESS, state SHALL become IDLE and data_read, data_write, stall_memory, address_error_memory SHALL be 0 from that edge.
REQ-022 Reset values: read_data_memory=0, data_byteenable=0, data_writedata=0, data_address=0.
REQ-023 An access interrupted by reset SHALL NOT be retried.

Structure
REQ-024 Opcode constants (LB 0x20, LH 0x21, LWL 0x22, LW 0x23, LBU 0x24, LHU 0x25, LWR 0x26, SB 0x28, SH 0x29, SW 0x2B) and the state enum SHALL live in shared package mips_pkg.
REQ-025 Lane selection/extension and LWL/LWR merging SHALL be one combinational sub-module, load_extend.

Verification
REQ-026 LW addr 0x100, waitrequest 2 cycles, readdata 0xDEADBEEF -> data_read high 3 cycles, stall 4 cycles, read_data_memory=0xDEADBEEF in DONE.
REQ-027 LB addr 0x103, readdata 0x80112233 -> byteenable 1111, result 0xFFFFFF80; LBU same -> 0x00000080.
REQ-028 SH addr 0x202, data 0x0000ABCD -> byteenable 1100, writedata 0xABCDABCD, data_write one cycle with waitrequest 0.
REQ-029 LWL addr 0x301, rt 0x11223344, word 0xAABBCCDD -> 0xCCDD3344; LWR addr 0x301 -> 0x11AABBCC.
REQ-030 SW addr 0x0002 -> address_error_memory one-cycle pulse, no data_write, stall 0.
REQ-031 Reset asserted in ACCESS with waitrequest 1 -> next edge IDLE, strobes 0, stall 0, no retry after reset release.
